// File: rtl/pipeline_control_unit_pkg.sv
// Shared encodings for the pipeline control unit: PC source selects and FSM states.
package pipeline_control_unit_pkg;

  localparam logic [1:0] PCSEL_PLUS4  = 2'd0;
  localparam logic [1:0] PCSEL_BRANCH = 2'd1;
  localparam logic [1:0] PCSEL_TRAP   = 2'd2;
  localparam logic [1:0] PCSEL_MEPC   = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_control_unit_perf_stall_counter.sv
// Free-running enable-increment counter that wraps modulo 2^CNT_W.
module perf_stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush arbiter for the 5-stage core: stage enables, flushes, PC select,
// interrupt-entry sequencing and a stall-cycle counter.
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             hazard_stall,
  input  logic             instr_wait,
  input  logic             data_wait,
  input  logic             branch_taken_EX,
  input  logic             mret_EX,
  input  logic [31:0]      branch_target_EX,
  input  logic [31:0]      pc_ID,
  input  logic             irq_pending,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       pc_sel,
  output logic             trap_entry,
  output logic [31:0]      mepc_o,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES);

  state_e     state;
  logic [1:0] drain_cnt;
  logic       accept_irq;

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pc_sel      = PCSEL_PLUS4;
    accept_irq  = 1'b0;

    case (state)
      ST_RUN: begin
        if (data_wait) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else if (irq_pending) begin
          // Squash IF/ID but let the EX instruction retire before the trap.
          accept_irq  = 1'b1;
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (branch_taken_EX || mret_EX) begin
          pc_sel      = branch_taken_EX ? PCSEL_BRANCH : PCSEL_MEPC;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (hazard_stall) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (instr_wait) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (data_wait) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      ST_TRAP: begin
        pc_sel      = PCSEL_TRAP;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // Drain counter only advances on cycles where MEM is not waiting on data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= ST_RUN;
      drain_cnt  <= 2'd0;
      mepc_o     <= 32'd0;
      trap_entry <= 1'b0;
    end else begin
      trap_entry <= 1'b0;
      case (state)
        ST_RUN: begin
          if (accept_irq) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_LOAD;
            mepc_o    <= branch_taken_EX ? branch_target_EX : pc_ID;
          end
        end
        ST_DRAIN: begin
          if (!data_wait) begin
            if (drain_cnt <= 2'd1) begin
              state      <= ST_TRAP;
              drain_cnt  <= 2'd0;
              trap_entry <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 2'd1;
            end
          end
        end
        ST_TRAP: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

  perf_stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .inc    (~pc_en),
    .count  (stall_count)
  );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Randomized and directed bench for pipeline_control_unit against a behavioural model.
module tb_pipeline_control_unit;

  localparam int DRAIN_CYCLES = 2;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        hazard_stall, instr_wait, data_wait, branch_taken_EX, mret_EX, irq_pending;
  logic [31:0] branch_target_EX, pc_ID;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic [1:0]  pc_sel;
  logic        trap_entry;
  logic [31:0] mepc_o, stall_count;

  logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic        s_if_id_flush, s_id_ex_flush, s_trap_entry;
  logic [1:0]  s_pc_sel;
  logic [31:0] s_mepc_o;
  logic [3:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  int          m_phase;
  int          m_left;
  logic [31:0] m_mepc;
  logic [31:0] m_stalls;
  logic        m_trap;

  logic [8:0] dut_ctl;
  assign dut_ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, pc_sel};

  pipeline_control_unit #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .hazard_stall(hazard_stall), .instr_wait(instr_wait),
    .data_wait(data_wait), .branch_taken_EX(branch_taken_EX), .mret_EX(mret_EX),
    .branch_target_EX(branch_target_EX), .pc_ID(pc_ID), .irq_pending(irq_pending),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_sel(pc_sel), .trap_entry(trap_entry), .mepc_o(mepc_o), .stall_count(stall_count)
  );

  // Narrow-counter instance so counter wrap is exercised within a short run.
  pipeline_control_unit #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(4)) dut_small (
    .clk_i(clk_i), .reset_i(reset_i), .hazard_stall(hazard_stall), .instr_wait(instr_wait),
    .data_wait(data_wait), .branch_taken_EX(branch_taken_EX), .mret_EX(mret_EX),
    .branch_target_EX(branch_target_EX), .pc_ID(pc_ID), .irq_pending(irq_pending),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
    .mem_wb_en(s_mem_wb_en), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .pc_sel(s_pc_sel), .trap_entry(s_trap_entry), .mepc_o(s_mepc_o),
    .stall_count(s_stall_count)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bits: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, pc_sel}
  function automatic logic [8:0] expected_ctl();
    if (m_phase == 2)                 return 9'b1_1111_11_10;
    if (data_wait)                    return 9'b0_0000_00_00;
    if (m_phase == 1 || irq_pending)  return 9'b0_1111_11_00;
    if (branch_taken_EX)              return 9'b1_1111_11_01;
    if (mret_EX)                      return 9'b1_1111_11_11;
    if (hazard_stall)                 return 9'b0_0111_01_00;
    if (instr_wait)                   return 9'b0_1111_10_00;
    return 9'b1_1111_00_00;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_left   = 0;
    m_mepc   = 32'd0;
    m_stalls = 32'd0;
    m_trap   = 1'b0;
  endtask

  task automatic check_regs();
    checkOutput("mepc", mepc_o, m_mepc);
    checkOutput("trap_entry", {31'd0, trap_entry}, {31'd0, m_trap});
    checkOutput("stall_count", stall_count, m_stalls);
    checkOutput("stall_w4", {28'd0, s_stall_count}, {28'd0, m_stalls[3:0]});
  endtask

  task automatic applyStimulus(input logic hz, input logic iw, input logic dw, input logic br,
                               input logic mr, input logic [31:0] tgt, input logic [31:0] pc,
                               input logic irq);
    logic [8:0] e;
    hazard_stall = hz; instr_wait = iw; data_wait = dw; branch_taken_EX = br;
    mret_EX = mr; branch_target_EX = tgt; pc_ID = pc; irq_pending = irq;
    #1;
    e = expected_ctl();
    checkOutput("ctl", {23'd0, dut_ctl}, {23'd0, e});
    @(posedge clk_i);
    if (!e[8]) m_stalls = m_stalls + 32'd1;
    case (m_phase)
      0: if (irq_pending && !data_wait) begin
        m_phase = 1;
        m_left  = DRAIN_CYCLES;
        m_mepc  = branch_taken_EX ? branch_target_EX : pc_ID;
      end
      1: if (!data_wait) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
    m_trap = (m_phase == 2);
    #1;
    check_regs();
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic reset_now();
    hazard_stall = 0; instr_wait = 0; data_wait = 0; branch_taken_EX = 0;
    mret_EX = 0; branch_target_EX = 0; pc_ID = 0; irq_pending = 0;
    reset_i = 1'b1;
    model_reset();
    #1;
    checkOutput("reset_ctl", {23'd0, dut_ctl}, {23'd0, expected_ctl()});
    check_regs();
    @(posedge clk_i);
    #1;
    checkOutput("reset_trap_hold", {31'd0, trap_entry}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_now();
    idle(1);

    // Load-use stall
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h40, 0);
    checkOutput("loaduse_cnt", stall_count, 32'd1);

    // Branch overrides hazard and instr_wait
    applyStimulus(1, 1, 0, 1, 0, 32'h100, 32'h44, 0);
    checkOutput("branch_cnt", stall_count, 32'd1);

    // data_wait beats redirect, then redirect proceeds
    applyStimulus(0, 0, 1, 1, 0, 32'h100, 32'h44, 0);
    applyStimulus(0, 0, 0, 1, 0, 32'h100, 32'h44, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h100, 32'h48, 0);

    // Plain interrupt
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h80, 1);
    checkOutput("irq_mepc", mepc_o, 32'h80);
    idle(2);
    checkOutput("irq_trap", {31'd0, trap_entry}, 32'd1);
    checkOutput("irq_pcsel", {30'd0, pc_sel}, 32'd2);
    idle(1);
    checkOutput("irq_back", {31'd0, trap_entry}, 32'd0);

    // Interrupt with branch in EX and data_wait during drain
    applyStimulus(0, 0, 0, 1, 0, 32'h200, 32'h84, 1);
    checkOutput("irqbr_mepc", mepc_o, 32'h200);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 32'h300, 32'h0, 0);
    idle(2);
    checkOutput("irqbr_trap", {31'd0, trap_entry}, 32'd1);
    idle(2);

    // Reset in the middle of DRAIN
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 32'h90, 1);
    idle(1);
    reset_now();
    idle(4);

    // Long stall burst to wrap the narrow counter
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC,
                    $urandom & 32'hFFFF_FFFC, $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
